// File: rtl/bp_cce_inv_sequencer.sv
// Invalidation sequencer behind the CCE directory: captures one sharer set,
// issues one invalidate per sharing LCE (lowest ID first, requester excluded),
// then collects acks and pulses done once every targeted LCE has answered.
module bp_cce_inv_sequencer #(
   parameter int num_lce_p         = 4,
   parameter int lce_id_width_p    = 2,
   parameter int lce_assoc_width_p = 3,
   parameter int paddr_width_p     = 40
) (
   input  logic                                    clk_i,
   input  logic                                    reset_n_i,
   input  logic                                    start_i,
   input  logic [paddr_width_p-1:0]                addr_i,
   input  logic [lce_id_width_p-1:0]               req_lce_i,
   input  logic [num_lce_p-1:0]                    sharers_hits_i,
   input  logic [num_lce_p*lce_assoc_width_p-1:0]  sharers_ways_i,
   output logic                                    busy_o,
   output logic                                    inv_v_o,
   input  logic                                    inv_ready_i,
   output logic [lce_id_width_p-1:0]               inv_lce_o,
   output logic [lce_assoc_width_p-1:0]            inv_way_o,
   output logic [paddr_width_p-1:0]                inv_addr_o,
   input  logic                                    ack_v_i,
   input  logic [lce_id_width_p-1:0]               ack_lce_i,
   output logic                                    done_v_o,
   output logic [lce_id_width_p:0]                 inv_count_o,
   output logic                                    err_o
);

   localparam int cnt_w_lp = lce_id_width_p + 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, DONE} state_e;

   state_e                                 state_q, state_n;
   logic [num_lce_p-1:0]                   mask_q, mask_n;    // still to be sent
   logic [num_lce_p-1:0]                   pend_q, pend_n;    // still to be acked
   logic [cnt_w_lp-1:0]                    cnt_q, cnt_n;
   logic                                   err_q;
   logic [paddr_width_p-1:0]               addr_q;
   logic [num_lce_p*lce_assoc_width_p-1:0] ways_q;
   logic [lce_id_width_p-1:0]              lce_q;
   logic [lce_assoc_width_p-1:0]           way_q;

   logic [num_lce_p-1:0]                   req_oh, ack_oh, sel_oh, new_mask;
   logic [lce_id_width_p-1:0]              sel_lce;
   logic [lce_assoc_width_p-1:0]           sel_way;
   logic                                   ack_ok;

   // Decode requester/ack IDs, pick the lowest pending-send LCE and its way.
   // Out-of-range requester IDs match no bit, so nothing is excluded.
   always_comb begin
      req_oh  = '0;
      ack_oh  = '0;
      sel_lce = '0;
      sel_way = '0;
      for (int i = 0; i < num_lce_p; i++) begin
         req_oh[i] = (req_lce_i == lce_id_width_p'(i));
         ack_oh[i] = (ack_lce_i == lce_id_width_p'(i));
      end
      sel_oh = mask_q & (~mask_q + num_lce_p'(1));
      for (int i = num_lce_p - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            sel_lce = lce_id_width_p'(i);
            sel_way = ways_q[i*lce_assoc_width_p +: lce_assoc_width_p];
         end
      end
      new_mask = sharers_hits_i & ~req_oh;
      // Legal only once the command has gone out and before it was acked
      ack_ok   = ack_v_i & |(ack_oh & pend_q & ~mask_q);
   end

   // Next-state, mask/pending bookkeeping and issue count
   always_comb begin
      state_n = state_q;
      mask_n  = mask_q;
      pend_n  = pend_q;
      cnt_n   = cnt_q;
      if (ack_ok) pend_n = pend_q & ~ack_oh;
      case (state_q)
         IDLE: if (start_i) begin
            mask_n  = new_mask;
            pend_n  = new_mask;
            cnt_n   = '0;
            state_n = (|new_mask) ? SEND : DONE;
         end
         SEND: if (inv_ready_i) begin
            mask_n = mask_q & ~sel_oh;
            cnt_n  = cnt_q + cnt_w_lp'(1);
            if (mask_n == '0) state_n = (pend_n == '0) ? DONE : WAIT_ACK;
         end
         WAIT_ACK: if (pend_n == '0) state_n = DONE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State and datapath registers; reset drops any in-flight request
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         mask_q  <= '0;
         pend_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         ways_q  <= '0;
         lce_q   <= '0;
         way_q   <= '0;
      end else begin
         state_q <= state_n;
         mask_q  <= mask_n;
         pend_q  <= pend_n;
         cnt_q   <= cnt_n;
         if (ack_v_i && !ack_ok) err_q <= 1'b1;
         if (state_q == IDLE && start_i) begin
            addr_q <= addr_i;
            ways_q <= sharers_ways_i;
         end
         // Remember the last presented target so it holds while not sending
         if (state_q == SEND) begin
            lce_q <= sel_lce;
            way_q <= sel_way;
         end
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign inv_v_o     = (state_q == SEND);
   assign inv_lce_o   = inv_v_o ? sel_lce : lce_q;
   assign inv_way_o   = inv_v_o ? sel_way : way_q;
   assign inv_addr_o  = addr_q;
   assign done_v_o    = (state_q == DONE);
   assign inv_count_o = cnt_q;
   assign err_o       = err_q;

endmodule
